// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan with anode guard, blanking and frame-aligned value commit
module seg7_scan_ctrl #(
  parameter int AN_NUM = 8,
  parameter int DIV_W  = 16,
  parameter int GUARD  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIV_W-1:0]      div_i,
  input  logic                  blank_en_i,
  input  logic [4*AN_NUM-1:0]   num_i,
  input  logic                  num_valid_i,
  output logic                  num_ready_o,
  output logic [6:0]            cath_o,
  output logic [AN_NUM-1:0]     an_o,
  output logic                  frame_o
);
  localparam int DW = $clog2(AN_NUM);
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic [1:0] {OFF, GRD, ON} state_t;
  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [4*AN_NUM-1:0] pending_q, active_q;
  logic                pend_full_q, commit, lit;
  logic [AN_NUM-1:0]   hi_zero, an_d;
  logic [6:0]          cath_d;
  logic [3:0]          nib;
  // hi_zero[i]: nibbles i..AN_NUM-1 of the displayed value are all zero
  for (genvar g = 0; g < AN_NUM; g++) begin : g_z
    if (g == AN_NUM - 1) begin : g_top
      assign hi_zero[g] = active_q[4*g +: 4] == 4'h0;
    end else begin : g_low
      assign hi_zero[g] = (active_q[4*g +: 4] == 4'h0) & hi_zero[g+1];
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    div_d   = div_q;
    commit  = 1'b0;
    if (!en_i) begin
      state_d = OFF;
      cnt_d   = '0;
      dig_d   = '0;
    end else if (state_q == OFF) begin
      state_d = GRD;
      cnt_d   = '0;
      dig_d   = '0;
      div_d   = div_i;
      commit  = 1'b1;
    end else if (state_q == GRD) begin
      cnt_d   = cnt_q + DIV_W'(1);
      state_d = (cnt_q == DIV_W'(GUARD - 1)) ? ON : GRD;
    end else if (cnt_q == div_q) begin
      state_d = GRD;
      cnt_d   = '0;
      div_d   = div_i;
      commit  = dig_q == DW'(AN_NUM - 1);
      dig_d   = commit ? '0 : dig_q + DW'(1);
    end else begin
      cnt_d   = cnt_q + DIV_W'(1);
    end
  end
  // outputs are computed for the next cycle so the registered pins line up with state_q
  assign nib    = active_q[4*dig_q +: 4];
  assign lit    = (state_d == ON) & ~(blank_en_i & (dig_q != '0) & hi_zero[dig_q]);
  assign an_d   = lit ? ~(AN_NUM'(1) << dig_q) : '1;
  assign cath_d = lit ? ~SEG[nib] : 7'h7F;
  assign num_ready_o = ~pend_full_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= OFF;
      cnt_q       <= '0;
      div_q       <= '0;
      dig_q       <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      active_q    <= '0;
      an_o        <= '1;
      cath_o      <= 7'h7F;
      frame_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      dig_q       <= dig_d;
      an_o        <= an_d;
      cath_o      <= cath_d;
      frame_o     <= commit;
      if (num_valid_i && !pend_full_q) pending_q <= num_i;
      if (commit && pend_full_q) active_q <= pending_q;
      pend_full_q <= (num_valid_i & ~pend_full_q) | (pend_full_q & ~commit);
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scenarios for the scan sequencer with hand-derived expected frames
module tb_seg7_scan_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [15:0] div_i = 16'd9;
  logic        blank_en_i = 1'b0;
  logic [31:0] num_i = '0;
  logic        num_valid_i = 1'b0;
  logic        num_ready_o;
  logic [6:0]  cath_o;
  logic [7:0]  an_o;
  logic        frame_o;
  int checks = 0;
  int errors = 0;
  logic [6:0] seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_ctrl #(.AN_NUM(8), .DIV_W(16), .GUARD(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .div_i(div_i), .blank_en_i(blank_en_i),
    .num_i(num_i), .num_valid_i(num_valid_i), .num_ready_o(num_ready_o),
    .cath_o(cath_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic send(input logic [31:0] v);
    num_i = v;
    num_valid_i = 1'b1;
    @(posedge clk_i);
    #1 num_valid_i = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      got = frame_o;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s frame_o timeout: got 0 expected 1 within 200 cycles", tag);
    end
  endtask

  // Starts on the negedge where frame_o is high; ends on the next frame's first negedge.
  task automatic verify_frame(input logic [31:0] v, input bit bl, input string tag);
    logic [7:0] ea;
    logic [6:0] ec;
    logic       ef, on;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 10; c++) begin
        on = (c >= 2) && !(bl && k > 0 && (v >> (4 * k)) == 32'h0);
        ea = on ? ~(8'h01 << k) : 8'hFF;
        ec = on ? ~seg[v[4*k +: 4]] : 7'h7F;
        ef = (k == 0 && c == 0);
        checks += 3;
        if (an_o !== ea) begin
          errors++;
          $display("FAIL %s an_o k=%0d c=%0d: got %h expected %h", tag, k, c, an_o, ea);
        end
        if (cath_o !== ec) begin
          errors++;
          $display("FAIL %s cath_o k=%0d c=%0d: got %h expected %h", tag, k, c, cath_o, ec);
        end
        if (frame_o !== ef) begin
          errors++;
          $display("FAIL %s frame_o k=%0d c=%0d: got %b expected %b", tag, k, c, frame_o, ef);
        end
        @(negedge clk_i);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_i);
    checks += 4;
    if (an_o !== 8'hFF) begin errors++; $display("FAIL reset an_o: got %h expected ff", an_o); end
    if (cath_o !== 7'h7F) begin errors++; $display("FAIL reset cath_o: got %h expected 7f", cath_o); end
    if (frame_o !== 1'b0) begin errors++; $display("FAIL reset frame_o: got %b expected 0", frame_o); end
    if (num_ready_o !== 1'b1) begin errors++; $display("FAIL reset num_ready_o: got %b expected 1", num_ready_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_scan;
    send(32'h76543210);
    checks++;
    if (num_ready_o !== 1'b0) begin errors++; $display("FAIL scan ready after send: got %b expected 0", num_ready_o); end
    en_i = 1'b1;
    wait_frame("scan");
    checks++;
    if (num_ready_o !== 1'b1) begin errors++; $display("FAIL scan ready after commit: got %b expected 1", num_ready_o); end
    verify_frame(32'h76543210, 1'b0, "scan1");
    verify_frame(32'h76543210, 1'b0, "scan2");
  endtask

  task automatic test_blank;
    blank_en_i = 1'b1;
    send(32'h00000A05);
    wait_frame("blank_a05");
    verify_frame(32'h00000A05, 1'b1, "blank_a05");
    send(32'h00000000);
    wait_frame("blank_zero");
    verify_frame(32'h00000000, 1'b1, "blank_zero");
    blank_en_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit stalled = 1;
    bit got = 0;
    send(32'h89ABCDEF);
    wait_frame("b2b_a");
    checks++;
    if (num_ready_o !== 1'b1) begin errors++; $display("FAIL b2b ready after A commit: got %b expected 1", num_ready_o); end
    repeat (2) @(negedge clk_i);
    checks += 2;
    if (an_o !== 8'hFE) begin errors++; $display("FAIL b2b A digit0 an_o: got %h expected fe", an_o); end
    if (cath_o !== ~seg[15]) begin errors++; $display("FAIL b2b A digit0 cath_o: got %h expected %h", cath_o, ~seg[15]); end
    repeat (20) @(negedge clk_i);
    send(32'h13579BDF);
    checks++;
    if (num_ready_o !== 1'b0) begin errors++; $display("FAIL b2b ready after B: got %b expected 0", num_ready_o); end
    num_i = 32'h2468ACE0;
    num_valid_i = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      got = frame_o;
      if (!got && num_ready_o !== 1'b0) stalled = 0;
    end
    checks += 3;
    if (!got) begin errors++; $display("FAIL b2b frame_o timeout: got 0 expected 1"); end
    if (!stalled) begin errors++; $display("FAIL b2b C stall: got ready=1 expected ready=0 before frame"); end
    if (num_ready_o !== 1'b1) begin errors++; $display("FAIL b2b ready at commit: got %b expected 1", num_ready_o); end
    verify_frame(32'h13579BDF, 1'b0, "b2b_b");
    num_valid_i = 1'b0;
    verify_frame(32'h2468ACE0, 1'b0, "b2b_c");
  endtask

  task automatic test_commit_collision;
    repeat (79) @(negedge clk_i);
    send(32'h0F1E2D3C);
    @(negedge clk_i);
    checks += 2;
    if (frame_o !== 1'b1) begin errors++; $display("FAIL collision frame_o: got %b expected 1", frame_o); end
    if (num_ready_o !== 1'b0) begin errors++; $display("FAIL collision ready: got %b expected 0", num_ready_o); end
    verify_frame(32'h2468ACE0, 1'b0, "collision_old");
    verify_frame(32'h0F1E2D3C, 1'b0, "collision_new");
  endtask

  task automatic test_enable_drop;
    repeat (24) @(negedge clk_i);
    checks++;
    if (an_o !== 8'hFB) begin errors++; $display("FAIL endrop lit an_o: got %h expected fb", an_o); end
    en_i = 1'b0;
    send(32'hFEDCBA98);
    @(negedge clk_i);
    checks += 3;
    if (an_o !== 8'hFF) begin errors++; $display("FAIL endrop dark an_o: got %h expected ff", an_o); end
    if (cath_o !== 7'h7F) begin errors++; $display("FAIL endrop dark cath_o: got %h expected 7f", cath_o); end
    if (num_ready_o !== 1'b0) begin errors++; $display("FAIL endrop pending kept: got %b expected 0", num_ready_o); end
    repeat (5) @(negedge clk_i);
    checks++;
    if (an_o !== 8'hFF) begin errors++; $display("FAIL endrop held dark an_o: got %h expected ff", an_o); end
    en_i = 1'b1;
    wait_frame("endrop");
    verify_frame(32'hFEDCBA98, 1'b0, "endrop");
  endtask

  task automatic test_async_reset;
    repeat (13) @(negedge clk_i);
    send(32'h11111111);
    #2 rst_i = 1'b1;
    #1;
    checks += 4;
    if (an_o !== 8'hFF) begin errors++; $display("FAIL arst an_o: got %h expected ff", an_o); end
    if (cath_o !== 7'h7F) begin errors++; $display("FAIL arst cath_o: got %h expected 7f", cath_o); end
    if (num_ready_o !== 1'b1) begin errors++; $display("FAIL arst num_ready_o: got %b expected 1", num_ready_o); end
    if (frame_o !== 1'b0) begin errors++; $display("FAIL arst frame_o: got %b expected 0", frame_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_frame("arst");
    verify_frame(32'h00000000, 1'b0, "arst1");
    verify_frame(32'h00000000, 1'b0, "arst2");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_back_to_back();
    test_commit_collision();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
